// File: rtl/reg_file_param.sv
// Parameterised register file with a per-register busy scoreboard, same-cycle
// write bypass on both read ports, and a one-register-per-cycle clear sweep.
module reg_file_param #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    RS,
    input  logic [AW-1:0]    RT,
    input  logic [AW-1:0]    RW,
    input  logic [WIDTH-1:0] DW,
    input  logic             RG_WE,
    input  logic             RSV,
    input  logic [AW-1:0]    RSV_A,
    input  logic             CLR,
    output logic [WIDTH-1:0] CRS,
    output logic [WIDTH-1:0] CRT,
    output logic             BUSY_RS,
    output logic             BUSY_RT,
    output logic             CLR_BUSY,
    output logic [0:0]       DBG_STATE
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [WIDTH-1:0] rf_q [DEPTH];
    logic [WIDTH-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    idx_d;

    logic idle;
    logic wr_ok;
    logic rsv_ok;
    logic rs_zero;
    logic rt_zero;

    assign idle    = (state_q == S_IDLE);
    assign rs_zero = (ZERO_REG != 0) && (RS == '0);
    assign rt_zero = (ZERO_REG != 0) && (RT == '0);

    // Writes and reserves are only accepted in IDLE when no sweep is being started.
    assign wr_ok  = RG_WE && idle && !CLR && !((ZERO_REG != 0) && (RW == '0));
    assign rsv_ok = RSV && idle && !CLR && !((ZERO_REG != 0) && (RSV_A == '0));

    always_comb begin
        CRS = rf_q[RS];
        if (rs_zero) begin
            CRS = '0;
        end else if (wr_ok && (RW == RS)) begin
            CRS = DW;
        end
        CRT = rf_q[RT];
        if (rt_zero) begin
            CRT = '0;
        end else if (wr_ok && (RW == RT)) begin
            CRT = DW;
        end
    end

    assign BUSY_RS   = rs_zero ? 1'b0 : busy_q[RS];
    assign BUSY_RT   = rt_zero ? 1'b0 : busy_q[RT];
    assign CLR_BUSY  = (state_q == S_SWEEP);
    assign DBG_STATE = state_q;

    always_comb begin
        rf_d    = rf_q;
        busy_d  = busy_q;
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (CLR) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                end else begin
                    if (wr_ok) begin
                        rf_d[RW]   = DW;
                        busy_d[RW] = 1'b0;
                    end
                    // Applied after the write so a same-address reserve wins.
                    if (rsv_ok) begin
                        busy_d[RSV_A] = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                rf_d[idx_q]   = '0;
                busy_d[idx_q] = 1'b0;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            busy_q  <= '0;
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            rf_q    <= rf_d;
            busy_q  <= busy_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule
